// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the PWM DAC path between the SAR converter and the
// PWM DAC generator.
//   dac_state_t        : generator control states (SETTLING, PENDING, STEADY)
//   DAC_WIDTH_DEFAULT  : default DAC code width, also used by the SAR side
//   per_cnt_inc()      : saturating increment for the 8-bit period counter
// ---------------------------------------------------------------------------
package dac_pkg;

    localparam int DAC_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        SETTLING = 2'd0,
        PENDING  = 2'd1,
        STEADY   = 2'd2
    } dac_state_t;

    // Saturating increment: the period counter sticks at its maximum instead
    // of wrapping back into the "not yet settled" range.
    function automatic logic [7:0] per_cnt_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_dac_gen.sv
// ---------------------------------------------------------------------------
// pwm_dac_gen
// PWM DAC generator. Accepts a duty code over a valid/ready handshake, holds
// it in a shadow register and swaps it into the active code only at a PWM
// period boundary, so the output never shows a partially-updated period.
// After a new code is applied, `settled` reports once the external RC filter
// has seen SETTLE_PERIODS complete periods at that code.
//
// Parameters
//   WIDTH           code width; PWM period is 2^WIDTH clocks
//   SETTLE_PERIODS  full periods at a new code before `settled` (1..255)
// Ports
//   clk          system clock
//   reset        synchronous reset, active low
//   code_in      requested duty code
//   code_valid   code_in is valid
//   code_ready   a code can be captured this cycle (registered)
//   pwm_out      PWM pin, high while the previous cnt < active_code (registered)
//   period_tick  high on the last cycle of every period (decoded from cnt)
//   settled      SETTLE_PERIODS full periods run at active_code (registered)
//   active_code  code currently being generated (registered)
// ---------------------------------------------------------------------------
module pwm_dac_gen
    import dac_pkg::*;
#(
    parameter int WIDTH          = DAC_WIDTH_DEFAULT,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             settled,
    output logic [WIDTH-1:0] active_code
);

    // The transition to STEADY happens on the wrap that would bring the
    // count to SETTLE_PERIODS, i.e. while per_cnt still holds one less.
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_PERIODS - 1);
    localparam logic [WIDTH-1:0] CNT_LAST    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] CODE_ZERO   = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_r;
    logic             pwm_out_r;
    logic [WIDTH-1:0] active_code_r;
    logic [WIDTH-1:0] pending_r;
    logic [7:0]       per_cnt_r;
    dac_state_t       state_r;
    logic             code_ready_r;
    logic             settled_r;

    logic             wrap_s;
    logic             capture_s;
    dac_state_t       state_nxt_s;
    logic [7:0]       per_cnt_nxt_s;
    logic [WIDTH-1:0] active_code_nxt_s;
    logic [WIDTH-1:0] pending_nxt_s;

    assign wrap_s    = (cnt_r == CNT_LAST);
    // code_ready_r is only high outside PENDING, so a capture can never
    // overwrite a code that is still waiting for its boundary.
    assign capture_s = code_valid && code_ready_r;

    // Next-state and datapath decisions for the control FSM.
    always_comb begin
        state_nxt_s       = state_r;
        per_cnt_nxt_s     = per_cnt_r;
        active_code_nxt_s = active_code_r;
        pending_nxt_s     = pending_r;

        if (capture_s) begin
            pending_nxt_s = code_in;
        end else begin
            pending_nxt_s = pending_r;
        end

        case (state_r)
            SETTLING: begin
                // A capture takes priority over a coinciding wrap: the
                // periods counted so far belong to a code being replaced.
                if (capture_s) begin
                    state_nxt_s   = PENDING;
                    per_cnt_nxt_s = 8'd0;
                end else if (wrap_s) begin
                    per_cnt_nxt_s = per_cnt_inc(per_cnt_r);
                    if (per_cnt_r >= SETTLE_LAST) begin
                        state_nxt_s = STEADY;
                    end else begin
                        state_nxt_s = SETTLING;
                    end
                end else begin
                    state_nxt_s   = SETTLING;
                    per_cnt_nxt_s = per_cnt_r;
                end
            end
            PENDING: begin
                // The apply wrap starts the new code's first period, so it
                // is not itself counted toward settling.
                if (wrap_s) begin
                    state_nxt_s       = SETTLING;
                    per_cnt_nxt_s     = 8'd0;
                    active_code_nxt_s = pending_r;
                end else begin
                    state_nxt_s       = PENDING;
                    active_code_nxt_s = active_code_r;
                end
            end
            STEADY: begin
                if (capture_s) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = STEADY;
                end
            end
            default: begin
                state_nxt_s   = SETTLING;
                per_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // State register and registered outputs; handshake/status flags are
    // decoded from the next state so they change on the same edge as it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= SETTLING;
            per_cnt_r     <= 8'd0;
            pending_r     <= CODE_ZERO;
            active_code_r <= CODE_ZERO;
            code_ready_r  <= 1'b1;
            settled_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            per_cnt_r     <= per_cnt_nxt_s;
            pending_r     <= pending_nxt_s;
            active_code_r <= active_code_nxt_s;
            code_ready_r  <= (state_nxt_s != PENDING);
            settled_r     <= (state_nxt_s == STEADY);
        end
    end

    // Free-running period counter and PWM comparator. Comparing against the
    // pre-increment count makes the pin lag the counter by one clock, and the
    // comparison can never be true for cnt = 2^WIDTH-1, so duty stays < 100%.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r     <= CODE_ZERO;
            pwm_out_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            pwm_out_r <= (cnt_r < active_code_r);
        end
    end

    assign code_ready  = code_ready_r;
    assign pwm_out     = pwm_out_r;
    assign period_tick = wrap_s;
    assign settled     = settled_r;
    assign active_code = active_code_r;

endmodule
